// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard receiver and key-event decoder
// Filters the device clock, deframes 11-bit frames and folds prefix bytes into key events.
module ps2_key_rx #(
   parameter int CLK_FILTER = 8,
   parameter int TIMEOUT    = 24000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        frame_err,
   output logic [7:0]  err_count
);
   localparam int FW = $clog2(CLK_FILTER + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    clk_sync_q, data_sync_q;
   logic          fclk_q, fclk_d;
   logic [FW-1:0] filt_q, filt_d;
   logic          fall, din;

   state_t        state_q, state_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_ok_q, par_ok_d;
   logic [TW-1:0] to_q, to_d;
   logic          good, err;

   logic          byte_valid_q, frame_err_q;
   logic [7:0]    byte_data_q, err_count_q;
   logic [10:0]   key_q;
   logic          ext_q, rel_q;
   logic [2:0]    skip_q;

   assign din        = data_sync_q[1];
   assign ps2_key    = key_q;
   assign byte_valid = byte_valid_q;
   assign byte_data  = byte_data_q;
   assign frame_err  = frame_err_q;
   assign err_count  = err_count_q;

   // fclk only follows the line after it has held a new level for CLK_FILTER cycles
   always_comb begin
      fclk_d = fclk_q;
      filt_d = '0;
      if (clk_sync_q[1] != fclk_q) begin
         if (filt_q == FW'(CLK_FILTER - 1)) fclk_d = clk_sync_q[1];
         else                               filt_d = filt_q + 1'b1;
      end
      fall = fclk_q & ~fclk_d;
   end

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_ok_d = par_ok_q;
      to_d     = to_q;
      good     = 1'b0;
      err      = 1'b0;
      if (state_q == IDLE) begin
         to_d = '0;
         if (fall && !din) begin
            state_d = DATA;
            bit_d   = 3'd0;
         end
      end else if (fall) begin
         to_d = '0;
         case (state_q)
            DATA: begin
               shift_d = {din, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_ok_d = ^{shift_q, din};
               state_d  = STOP;
            end
            default: begin
               if (din && par_ok_q) good = 1'b1;
               else                 err  = 1'b1;
               state_d = IDLE;
            end
         endcase
      end else if (to_q == TW'(TIMEOUT - 1)) begin
         err     = 1'b1;
         state_d = IDLE;
         to_d    = '0;
      end else begin
         to_d = to_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_q   <= 2'b11;
         data_sync_q  <= 2'b11;
         fclk_q       <= 1'b1;
         filt_q       <= '0;
         state_q      <= IDLE;
         bit_q        <= 3'd0;
         shift_q      <= 8'd0;
         par_ok_q     <= 1'b0;
         to_q         <= '0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= 8'd0;
         frame_err_q  <= 1'b0;
         err_count_q  <= 8'd0;
      end else begin
         clk_sync_q   <= {clk_sync_q[0], ps2_clk};
         data_sync_q  <= {data_sync_q[0], ps2_data};
         fclk_q       <= fclk_d;
         filt_q       <= filt_d;
         state_q      <= state_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         par_ok_q     <= par_ok_d;
         to_q         <= to_d;
         byte_valid_q <= good;
         frame_err_q  <= err;
         if (good) byte_data_q <= shift_q;
         if (err && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end
   end

   // Event stage runs one cycle behind the byte stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_q  <= 11'd0;
         ext_q  <= 1'b0;
         rel_q  <= 1'b0;
         skip_q <= 3'd0;
      end else if (frame_err_q) begin
         ext_q <= 1'b0;
         rel_q <= 1'b0;
      end else if (byte_valid_q) begin
         if (skip_q != 3'd0) begin
            skip_q <= skip_q - 3'd1;
         end else begin
            case (byte_data_q)
               8'hE1: skip_q <= 3'd7;
               8'hE0: ext_q  <= 1'b1;
               8'hF0: rel_q  <= 1'b1;
               8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
               end
               default: begin
                  key_q <= {~key_q[10], ~rel_q, ext_q, byte_data_q};
                  ext_q <= 1'b0;
                  rel_q <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - scoreboard bench for ps2_key_rx
module tb_ps2_key_rx;
   localparam int FILT = 4;
   localparam int TO   = 200;

   logic        clk = 1'b0;
   logic        reset;
   logic        ps2_clk, ps2_data;
   logic [10:0] ps2_key;
   logic        byte_valid, frame_err;
   logic [7:0]  byte_data, err_count;

   ps2_key_rx #(.CLK_FILTER(FILT), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .ps2_key(ps2_key), .byte_valid(byte_valid), .byte_data(byte_data),
      .frame_err(frame_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          exp_errcnt = 0;
   logic        exp_tog = 1'b0;
   logic [10:0] last_key = 11'd0;
   logic [7:0]  qb[$];
   logic [7:0]  qe[$];
   logic [10:0] qk[$];
   logic [7:0]  mexp8;
   logic [10:0] mexp11;

   task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      repeat (3) @(posedge clk);
      ps2_data = b;
      repeat (4) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (7) @(posedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] v, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
      send_bit(~(^v) ^ bad_par);
      send_bit(1'b1);
      ps2_data = 1'b1;
      repeat (8) @(posedge clk);
   endtask

   task automatic good_byte(input logic [7:0] v);
      qb.push_back(v);
      send_frame(v, 1'b0);
   endtask

   task automatic push_key(input logic [9:0] k);
      exp_tog = ~exp_tog;
      qk.push_back({exp_tog, k});
   endtask

   task automatic push_err();
      exp_errcnt = (exp_errcnt == 255) ? 255 : exp_errcnt + 1;
      qe.push_back(8'(exp_errcnt));
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((qb.size() + qk.size() + qe.size()) != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk(name, 11'(qb.size() + qk.size() + qe.size()), 11'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ps2_key"}, ps2_key, 11'd0);
      chk({tag, " byte_valid"}, {10'd0, byte_valid}, 11'd0);
      chk({tag, " byte_data"}, {3'd0, byte_data}, 11'd0);
      chk({tag, " frame_err"}, {10'd0, frame_err}, 11'd0);
      chk({tag, " err_count"}, {3'd0, err_count}, 11'd0);
   endtask

   initial begin
      reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
      fork
         forever begin
            @(negedge clk);
            if (reset) begin
               last_key = ps2_key;
            end else begin
               if (byte_valid) begin
                  if (qb.size() == 0) chk("byte_valid spurious", {10'd0, byte_valid}, 11'd0);
                  else begin
                     mexp8 = qb.pop_front();
                     chk("byte_data", {3'd0, byte_data}, {3'd0, mexp8});
                  end
               end
               if (frame_err) begin
                  if (qe.size() == 0) chk("frame_err spurious", {10'd0, frame_err}, 11'd0);
                  else begin
                     mexp8 = qe.pop_front();
                     chk("err_count", {3'd0, err_count}, {3'd0, mexp8});
                  end
               end
               if (ps2_key !== last_key) begin
                  if (qk.size() == 0) chk("ps2_key spurious", ps2_key, last_key);
                  else begin
                     mexp11 = qk.pop_front();
                     chk("ps2_key", ps2_key, mexp11);
                  end
                  last_key = ps2_key;
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      @(posedge clk); #3 reset = 1'b0;
      repeat (10) @(posedge clk);

      push_key(10'h229); good_byte(8'h29);
      push_key(10'h229); good_byte(8'h29);
      drain("make 29");

      good_byte(8'hE0); good_byte(8'hF0);
      push_key(10'h175); good_byte(8'h75);
      good_byte(8'hE0);
      push_key(10'h375); good_byte(8'h75);
      drain("extended");

      good_byte(8'hE0);
      push_err(); send_frame(8'h1C, 1'b1);
      good_byte(8'hF0);
      push_key(10'h01C); good_byte(8'h1C);
      drain("parity");

      good_byte(8'hE0);
      push_err();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      ps2_data = 1'b1;
      repeat (TO + 10) @(posedge clk);
      push_key(10'h216); good_byte(8'h16);
      drain("timeout");

      good_byte(8'hE1); good_byte(8'h14); good_byte(8'h77); good_byte(8'hE1);
      good_byte(8'hF0); good_byte(8'h14); good_byte(8'hF0); good_byte(8'h77);
      good_byte(8'hFA);
      push_key(10'h205); good_byte(8'h05);
      good_byte(8'hAA);
      drain("pause");

      ps2_data = 1'b0; ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (20) @(posedge clk);
      push_key(10'h229); good_byte(8'h29);
      drain("glitch");

      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(i[0]);
      @(posedge clk); #3 reset = 1'b1;
      #1 chk_zero("midframe reset");
      ps2_data = 1'b1;
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      exp_tog = 1'b0; exp_errcnt = 0;
      repeat (10) @(posedge clk);
      push_key(10'h26B); good_byte(8'h6B);
      drain("after reset");

      for (int i = 0; i < 300; i++) begin
         push_err();
         send_frame(8'h1C, 1'b1);
      end
      drain("saturate");
      chk("err_count saturated", {3'd0, err_count}, 11'd255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
